mbist_march_controller: RTL and testbench

- BIST-side driver for the memory input multiplexer.
- On `start`, it takes the memory path by asserting `Nbart`, then runs a March C- sequence over every address.
- Writes go out on the `bist_*` bus; read data is checked against expected values, with the result reported as `done`/`fail`/`fail_addr`.
- Sits between the test access logic and the multiplexer's BIST input; the memory's read data returns directly to it.

---
 rtl/mbist_march_controller.sv | 187 ++++++++++++++++++
 tb/tb_mbist_march_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_controller.sv
// March C- memory BIST controller: drives the BIST side of the memory
// input multiplexer and checks read data against the expected background.
module mbist_march_controller #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  Nbart,
   output logic [ADDR_WIDTH-1:0] bist_addr,
   output logic [DATA_WIDTH-1:0] bist_wdata,
   output logic                  bist_we,
   output logic                  bist_re,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [2:0]            ELEM_LAST = 3'd5;

   state_e                state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic                  op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  cmp_vld_q, cmp_vld_d;
   logic                  cmp_exp_q, cmp_exp_d;
   logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
   logic                  fail_q, fail_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

   logic is_read;
   logic rbit;
   logic wbit;
   logic last_op;
   logic desc;
   logic last_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         elem_q      <= '0;
         op_q        <= 1'b0;
         addr_q      <= '0;
         cmp_vld_q   <= 1'b0;
         cmp_exp_q   <= 1'b0;
         cmp_addr_q  <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         cmp_vld_q   <= cmp_vld_d;
         cmp_exp_q   <= cmp_exp_d;
         cmp_addr_q  <= cmp_addr_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
      end
   end

   // Element decode: elements 1-4 are read-then-write, 0 and 5 single-op.
   always_comb begin
      is_read = 1'b0;
      rbit    = 1'b0;
      wbit    = 1'b0;
      last_op = 1'b1;
      unique case (elem_q)
         3'd0: begin
            wbit = 1'b0;
         end
         3'd1, 3'd3: begin
            is_read = !op_q;
            rbit    = 1'b0;
            wbit    = 1'b1;
            last_op = op_q;
         end
         3'd2, 3'd4: begin
            is_read = !op_q;
            rbit    = 1'b1;
            wbit    = 1'b0;
            last_op = op_q;
         end
         3'd5: begin
            is_read = 1'b1;
         end
         default: begin
            is_read = 1'b0;
         end
      endcase
   end

   assign desc      = (elem_q >= 3'd3);
   assign last_addr = desc ? (addr_q == '0) : (addr_q == ADDR_MAX);

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      op_d        = op_q;
      addr_d      = addr_q;
      cmp_vld_d   = 1'b0;
      cmp_exp_d   = cmp_exp_q;
      cmp_addr_d  = cmp_addr_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      Nbart       = 1'b0;
      bist_addr   = '0;
      bist_wdata  = '0;
      bist_we     = 1'b0;
      bist_re     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      // Only the first mismatch of a run is recorded.
      if (cmp_vld_q && !fail_q &&
          (mem_rdata != {DATA_WIDTH{cmp_exp_q}})) begin
         fail_d      = 1'b1;
         fail_addr_d = cmp_addr_q;
      end

      unique case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               state_d     = RUN;
               elem_d      = '0;
               op_d        = 1'b0;
               addr_d      = '0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
            end
         end
         RUN: begin
            Nbart     = 1'b1;
            busy      = 1'b1;
            bist_addr = addr_q;
            if (is_read) begin
               bist_re    = 1'b1;
               cmp_vld_d  = 1'b1;
               cmp_exp_d  = rbit;
               cmp_addr_d = addr_q;
            end else begin
               bist_we    = 1'b1;
               bist_wdata = {DATA_WIDTH{wbit}};
            end
            if (!last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!last_addr) begin
                  addr_d = desc ? (addr_q - ADDR_ONE)
                                : (addr_q + ADDR_ONE);
               end else if (elem_q == ELEM_LAST) begin
                  state_d = FLUSH;
               end else begin
                  elem_d = elem_q + 3'd1;
                  addr_d = (elem_q >= 3'd2) ? ADDR_MAX : '0;
               end
            end
         end
         FLUSH: begin
            Nbart   = 1'b1;
            busy    = 1'b1;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_mbist_march_controller.sv
// Directed bench for the March C- BIST controller with a read-first
// memory model that can inject stuck-at faults.
module tb_mbist_march_controller;

   localparam int AW = 2;
   localparam int DW = 10;
   localparam int NOPS = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] mem_rdata;
   logic          Nbart;
   logic [AW-1:0] bist_addr;
   logic [DW-1:0] bist_wdata;
   logic          bist_we;
   logic          bist_re;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] mem [4];
   logic [AW-1:0] sa0_addr = '0;
   logic [DW-1:0] sa0_mask = '0;
   logic [AW-1:0] sa1_addr = '0;
   logic [DW-1:0] sa1_mask = '0;

   // expected op per cycle: 0=w0 1=w1 2=r0 3=r1
   int exp_op [1:NOPS];
   int exp_ad [1:NOPS];

   mbist_march_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .mem_rdata(mem_rdata),
      .Nbart(Nbart),
      .bist_addr(bist_addr),
      .bist_wdata(bist_wdata),
      .bist_we(bist_we),
      .bist_re(bist_re),
      .busy(busy),
      .done(done),
      .fail(fail),
      .fail_addr(fail_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      logic [DW-1:0] d;
      d = mem[bist_addr];
      if (bist_addr == sa0_addr) d = d & ~sa0_mask;
      if (bist_addr == sa1_addr) d = d | sa1_mask;
      if (bist_re) mem_rdata <= d;
      if (bist_we) mem[bist_addr] <= bist_wdata;
   end

   task automatic build_seq();
      int c = 1;
      for (int a = 0; a < 4; a++) begin
         exp_op[c] = 0; exp_ad[c] = a; c++;
      end
      for (int a = 0; a < 4; a++) begin
         exp_op[c] = 2; exp_ad[c] = a; c++;
         exp_op[c] = 1; exp_ad[c] = a; c++;
      end
      for (int a = 0; a < 4; a++) begin
         exp_op[c] = 3; exp_ad[c] = a; c++;
         exp_op[c] = 0; exp_ad[c] = a; c++;
      end
      for (int a = 3; a >= 0; a--) begin
         exp_op[c] = 2; exp_ad[c] = a; c++;
         exp_op[c] = 1; exp_ad[c] = a; c++;
      end
      for (int a = 3; a >= 0; a--) begin
         exp_op[c] = 3; exp_ad[c] = a; c++;
         exp_op[c] = 0; exp_ad[c] = a; c++;
      end
      for (int a = 3; a >= 0; a--) begin
         exp_op[c] = 2; exp_ad[c] = a; c++;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs a full test from a start pulse. fail_cyc is the first cycle
   // in which fail must read 1 (0 = clean run).
   task automatic run_test(input string nm, input int fail_cyc,
                           input logic [AW-1:0] faddr, input int mid_start);
      logic          xfail;
      logic [AW-1:0] xaddr;
      logic [3:0]    xctl;
      logic [DW-1:0] xwd;
      pulse_start();
      for (int c = 1; c <= NOPS + 2; c++) begin
         xfail = (fail_cyc != 0) && (c >= fail_cyc);
         xaddr = xfail ? faddr : '0;
         total++;
         if (fail !== xfail || fail_addr !== xaddr) begin
            bad++;
            $display("FAIL %s fail c=%0d got %b/%0d want %b/%0d",
                     nm, c, fail, fail_addr, xfail, xaddr);
         end
         if (c <= NOPS) begin
            xctl = {1'b1, 1'b1, exp_op[c] < 2, exp_op[c] >= 2};
            xwd = (exp_op[c] == 1) ? '1 : '0;
            total++;
            if ({Nbart, busy, bist_we, bist_re} !== xctl ||
                bist_addr !== AW'(exp_ad[c]) || bist_wdata !== xwd ||
                done !== 1'b0) begin
               bad++;
               $display("FAIL %s op c=%0d got nb/bsy/we/re=%b a=%0d wd=%h dn=%b want %b a=%0d wd=%h dn=0",
                        nm, c, {Nbart, busy, bist_we, bist_re},
                        bist_addr, bist_wdata, done, xctl, exp_ad[c], xwd);
            end
         end else if (c == NOPS + 1) begin
            total++;
            if (bist_we !== 1'b0 || bist_re !== 1'b0 || done !== 1'b0) begin
               bad++;
               $display("FAIL %s flush got we=%b re=%b done=%b want 0 0 0",
                        nm, bist_we, bist_re, done);
            end
         end else begin
            total++;
            if ({done, busy, Nbart, bist_we, bist_re} !== 5'b10000) begin
               bad++;
               $display("FAIL %s done got dn/bsy/nb/we/re=%b want 10000",
                        nm, {done, busy, Nbart, bist_we, bist_re});
            end
         end
         if (c == mid_start) start = 1'b1;
         if (c < NOPS + 2) begin
            @(posedge clk);
            #1;
            start = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1 || fail !== (fail_cyc != 0) || fail_addr !== faddr) begin
         bad++;
         $display("FAIL %s hold got done=%b fail=%b fa=%0d want 1 %b %0d",
                  nm, done, fail, fail_addr, fail_cyc != 0, faddr);
      end
   endtask

   task automatic check_zero(input string nm);
      total++;
      if ({Nbart, bist_addr, bist_wdata, bist_we, bist_re,
           busy, done, fail, fail_addr} !== '0) begin
         bad++;
         $display("FAIL %s outputs nb=%b a=%0d wd=%h we=%b re=%b bsy=%b dn=%b f=%b fa=%0d want all 0",
                  nm, Nbart, bist_addr, bist_wdata, bist_we, bist_re,
                  busy, done, fail, fail_addr);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_zero("idle");
   endtask

   task automatic test_clean();
      run_test("clean", 0, '0, 0);
   endtask

   task automatic test_stuck0();
      sa0_addr = 2'd2;
      sa0_mask = 10'h008;
      // M2 r1 @2 is cycle 17; compare in 18; fail visible 19
      run_test("sa0", 19, 2'd2, 0);
      sa0_mask = '0;
   endtask

   task automatic test_stuck1();
      sa1_addr = 2'd0;
      sa1_mask = 10'h001;
      // M1 r0 @0 is cycle 5; fail visible 7
      run_test("sa1", 7, 2'd0, 0);
   endtask

   task automatic test_restart_fixed();
      sa1_mask = '0;
      run_test("restart", 0, '0, 0);
   endtask

   task automatic test_mid_reset();
      pulse_start();
      repeat (24) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || Nbart !== 1'b1) begin
         bad++;
         $display("FAIL midrst pre got busy=%b nb=%b want 1 1", busy, Nbart);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst_async");
      @(posedge clk);
      #1;
      check_zero("midrst_held");
      @(negedge clk);
      rst_n = 1'b1;
      run_test("after_rst", 0, '0, 0);
   endtask

   task automatic test_start_ignored();
      run_test("mid_start", 0, '0, 20);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      mem_rdata = '0;
      build_seq();
      test_reset();
      test_clean();
      test_stuck0();
      test_stuck1();
      test_restart_fixed();
      test_mid_reset();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
